// File: rtl/matrix_pkg.sv
// ---------------------------------------------------------------------------
// matrix_pkg
//    Shared geometry and types for the LED-matrix shift-register stream.
//    The driver side and the capture side both import this package so that
//    the row word layout and row index width always agree.
//
//    Contents:
//       ROWS, COLS, SHIFT_BITS  matrix geometry (3 colour groups per column)
//       ROW_IDX_W               width of a binary row index
//       row_word_t              one shifted row word
//       row_idx_t               binary row index
//       row_sel_t               one-hot row select (KATOT)
//       onehot_to_idx()         binary position of the set bit of a row select
// ---------------------------------------------------------------------------
package matrix_pkg;

   localparam int ROWS       = 8;
   localparam int COLS       = 8;
   localparam int SHIFT_BITS = 3 * COLS;
   localparam int ROW_IDX_W  = (ROWS > 1) ? $clog2(ROWS) : 1;

   typedef logic [SHIFT_BITS-1:0] row_word_t;
   typedef logic [ROW_IDX_W-1:0]  row_idx_t;
   typedef logic [ROWS-1:0]       row_sel_t;

   // Only meaningful when sel is one-hot; callers qualify it with $onehot.
   function automatic row_idx_t onehot_to_idx(row_sel_t sel);
      row_idx_t idx;
      idx = '0;
      for (int r = 0; r < ROWS; r++) begin
         if (sel[r]) begin
            idx = row_idx_t'(r);
         end
      end
      return idx;
   endfunction

endpackage

// File: rtl/matrix_stream_capture_sync_edge.sv
// ---------------------------------------------------------------------------
// sync_edge
//    Multi-flop synchroniser for one asynchronous strobe followed by a
//    rising-edge detector working on the synchronised level.
//
//    Ports:
//       clk      system clock
//       reset_n  asynchronous active-low reset
//       din      asynchronous strobe input
//       rise     one-cycle pulse when the synchronised level goes 0 -> 1
// ---------------------------------------------------------------------------
module sync_edge #(
   parameter int STAGES = 2
) (
   input  logic clk,
   input  logic reset_n,
   input  logic din,
   output logic rise
);

   logic [STAGES-1:0] chain;
   logic              prev;

   // Synchroniser chain plus one extra flop remembering the previous
   // synchronised level, so the edge is judged on settled values only.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         chain <= '0;
         prev  <= 1'b0;
      end else begin
         chain <= {chain[STAGES-2:0], din};
         prev  <= chain[STAGES-1];
      end
   end

   assign rise = chain[STAGES-1] & ~prev;

endmodule

// File: rtl/matrix_stream_capture.sv
// ---------------------------------------------------------------------------
// matrix_stream_capture
//    Receive-side decoder for the LED-matrix shift-register stream. It
//    deserialises each row word, tags it with the row selected on KATOT,
//    rebuilds the full frame and raises sticky flags on malformed traffic.
//
//    Ports:
//       clk, reset_n        system clock, asynchronous active-low reset
//       sh_cp, st_cp, ds    shift clock, latch clock, serial data (async)
//       oe_n, sr_clr_n      output enable and shift-register clear (async)
//       katot               one-hot row select (async)
//       row_word, row_idx   last committed row word and its row index
//       row_valid           one-cycle pulse per commit
//       occupancy           per-pixel OR of the three colour bits
//       frame_valid         pulse when every row has committed once
//       len_err, row_err,
//       oe_err              sticky error flags
//       err_clr             synchronous clear of the sticky flags
// ---------------------------------------------------------------------------
module matrix_stream_capture
   import matrix_pkg::*;
#(
   parameter int SYNC_STAGES     = 2,
   parameter bit DATA_ACTIVE_LOW = 1'b1
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 sh_cp,
   input  logic                 st_cp,
   input  logic                 ds,
   input  logic                 oe_n,
   input  logic                 sr_clr_n,
   input  logic [ROWS-1:0]      katot,
   output logic [SHIFT_BITS-1:0] row_word,
   output logic [ROW_IDX_W-1:0] row_idx,
   output logic                 row_valid,
   output logic [ROWS*COLS-1:0] occupancy,
   output logic                 frame_valid,
   output logic                 len_err,
   output logic                 row_err,
   output logic                 oe_err,
   input  logic                 err_clr
);

   localparam int                CNT_W    = $clog2(SHIFT_BITS + 2);
   localparam logic [CNT_W-1:0]  CNT_FULL = CNT_W'(SHIFT_BITS);
   localparam logic [CNT_W-1:0]  CNT_SAT  = CNT_W'(SHIFT_BITS + 1);

   logic                   sh_rise;
   logic                   st_rise;
   logic [SYNC_STAGES-1:0] ds_sync;
   logic [SYNC_STAGES-1:0] oe_sync;
   logic [SYNC_STAGES-1:0] clr_sync;
   row_sel_t               katot_sync [SYNC_STAGES];
   logic                   ds_s;
   logic                   oe_n_s;
   logic                   sr_clr_n_s;
   row_sel_t               katot_s;
   row_sel_t               katot_prev;

   row_word_t              sr;
   logic [CNT_W-1:0]       cnt;
   row_word_t              frame [ROWS];
   row_sel_t               seen;

   logic                   kat_onehot;
   row_idx_t               kat_idx;
   logic                   len_hit;
   logic                   row_hit;
   logic                   oe_hit;
   logic                   commit;
   row_word_t              commit_word;
   row_sel_t               seen_next;
   logic                   frame_done;

   sync_edge #(.STAGES(SYNC_STAGES)) u_sh_edge (
      .clk     (clk),
      .reset_n (reset_n),
      .din     (sh_cp),
      .rise    (sh_rise)
   );

   sync_edge #(.STAGES(SYNC_STAGES)) u_st_edge (
      .clk     (clk),
      .reset_n (reset_n),
      .din     (st_cp),
      .rise    (st_rise)
   );

   // Level inputs use the same depth as the strobes so that ds and katot
   // are sampled in step with the shift/latch edges they belong to.
   // oe_n resets to 1 (blanked) so the first katot settle after reset is
   // not mistaken for a row switch with the outputs lit.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         ds_sync  <= '0;
         oe_sync  <= '1;
         clr_sync <= '0;
         for (int i = 0; i < SYNC_STAGES; i++) begin
            katot_sync[i] <= '0;
         end
      end else begin
         ds_sync       <= {ds_sync[SYNC_STAGES-2:0], ds};
         oe_sync       <= {oe_sync[SYNC_STAGES-2:0], oe_n};
         clr_sync      <= {clr_sync[SYNC_STAGES-2:0], sr_clr_n};
         katot_sync[0] <= katot;
         for (int i = 1; i < SYNC_STAGES; i++) begin
            katot_sync[i] <= katot_sync[i-1];
         end
      end
   end

   assign ds_s       = ds_sync[SYNC_STAGES-1];
   assign oe_n_s     = oe_sync[SYNC_STAGES-1];
   assign sr_clr_n_s = clr_sync[SYNC_STAGES-1];
   assign katot_s    = katot_sync[SYNC_STAGES-1];

   // Latch decision is made on the pre-shift sr/cnt, which gives the
   // 74HC595 ordering when shift and latch edges land in the same cycle.
   always_comb begin
      kat_onehot  = $onehot(katot_s);
      kat_idx     = onehot_to_idx(katot_s);
      len_hit     = st_rise && (cnt != CNT_FULL);
      row_hit     = st_rise && (cnt == CNT_FULL) && !kat_onehot;
      commit      = st_rise && (cnt == CNT_FULL) && kat_onehot;
      oe_hit      = (katot_s != katot_prev) && !oe_n_s;
      commit_word = DATA_ACTIVE_LOW ? ~sr : sr;
      seen_next   = seen | (row_sel_t'(1) << kat_idx);
      frame_done  = &seen_next;
   end

   // Shift register and bit counter. A same-cycle latch consumes the old
   // word, so the freshly shifted bit becomes the first bit of the next one.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sr  <= '0;
         cnt <= '0;
      end else if (!sr_clr_n_s) begin
         sr  <= '0;
         cnt <= '0;
      end else if (sh_rise) begin
         sr <= {sr[SHIFT_BITS-2:0], ds_s};
         if (st_rise) begin
            cnt <= CNT_W'(1);
         end else if (cnt != CNT_SAT) begin
            cnt <= cnt + CNT_W'(1);
         end
      end else if (st_rise) begin
         cnt <= '0;
      end
   end

   // Commit path: publish the row, store it in the frame buffer and track
   // which rows have arrived since the last completed frame.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         row_word    <= '0;
         row_idx     <= '0;
         row_valid   <= 1'b0;
         frame_valid <= 1'b0;
         seen        <= '0;
         for (int r = 0; r < ROWS; r++) begin
            frame[r] <= '0;
         end
      end else begin
         row_valid   <= commit;
         frame_valid <= commit && frame_done;
         if (commit) begin
            row_word       <= commit_word;
            row_idx        <= kat_idx;
            frame[kat_idx] <= commit_word;
            seen           <= frame_done ? '0 : seen_next;
         end
      end
   end

   // Sticky error flags; err_clr wins over any error raised in that cycle.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         len_err    <= 1'b0;
         row_err    <= 1'b0;
         oe_err     <= 1'b0;
         katot_prev <= '0;
      end else begin
         katot_prev <= katot_s;
         if (err_clr) begin
            len_err <= 1'b0;
            row_err <= 1'b0;
            oe_err  <= 1'b0;
         end else begin
            if (len_hit) len_err <= 1'b1;
            if (row_hit) row_err <= 1'b1;
            if (oe_hit)  oe_err  <= 1'b1;
         end
      end
   end

   // Pixel occupancy: a column is lit if any of its three colour bits is.
   always_comb begin
      occupancy = '0;
      for (int r = 0; r < ROWS; r++) begin
         for (int c = 0; c < COLS; c++) begin
            occupancy[r*COLS+c] = frame[r][c] | frame[r][c+COLS] | frame[r][c+2*COLS];
         end
      end
   end

endmodule

// File: tb/tb_matrix_stream_capture.sv
// ---------------------------------------------------------------------------
// tb_matrix_stream_capture
//    Self-checking bench for matrix_stream_capture. Drives the serial stream
//    like the matrix driver would and compares against a queue/array model.
// ---------------------------------------------------------------------------
module tb_matrix_stream_capture;
   import matrix_pkg::*;

   localparam bit DAL = 1'b1;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        sh_cp, st_cp, ds, oe_n, sr_clr_n, err_clr;
   logic [7:0]  katot;
   logic [23:0] row_word;
   logic [2:0]  row_idx;
   logic        row_valid, frame_valid, len_err, row_err, oe_err;
   logic [63:0] occupancy;

   int checks = 0;
   int errors = 0;
   int rv_count = 0;
   int fv_count = 0;

   // Behavioural model state
   bit          model_q[$];
   logic [23:0] m_frame [8];
   logic [7:0]  m_seen;
   int          exp_rv = 0;
   int          exp_fv = 0;
   logic [23:0] exp_word;
   int          exp_idx;
   bit          m_len, m_row, m_oe;

   always #5 clk = ~clk;

   matrix_stream_capture #(.SYNC_STAGES(2), .DATA_ACTIVE_LOW(DAL)) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .sh_cp       (sh_cp),
      .st_cp       (st_cp),
      .ds          (ds),
      .oe_n        (oe_n),
      .sr_clr_n    (sr_clr_n),
      .katot       (katot),
      .row_word    (row_word),
      .row_idx     (row_idx),
      .row_valid   (row_valid),
      .occupancy   (occupancy),
      .frame_valid (frame_valid),
      .len_err     (len_err),
      .row_err     (row_err),
      .oe_err      (oe_err),
      .err_clr     (err_clr)
   );

   // Count output pulses on the opposite edge.
   always @(negedge clk) begin
      if (row_valid) rv_count++;
      if (frame_valid) fv_count++;
   end

   function automatic void model_reset();
      model_q.delete();
      for (int r = 0; r < 8; r++) m_frame[r] = '0;
      m_seen   = '0;
      m_len    = 1'b0;
      m_row    = 1'b0;
      m_oe     = 1'b0;
      exp_word = '0;
      exp_idx  = 0;
   endfunction

   // Latch rule: exactly 24 bits and exactly one row selected, else error.
   function automatic void model_latch();
      logic [23:0] raw;
      int          idx;
      if (model_q.size() != 24) begin
         m_len = 1'b1;
      end else if ($countones(katot) != 1) begin
         m_row = 1'b1;
      end else begin
         raw = '0;
         foreach (model_q[i]) raw = raw * 2 + 24'(model_q[i]);
         idx = 0;
         for (int r = 0; r < 8; r++) if (katot[r]) idx = r;
         exp_word     = DAL ? ~raw : raw;
         exp_idx      = idx;
         m_frame[idx] = exp_word;
         m_seen[idx]  = 1'b1;
         exp_rv++;
         if (m_seen == 8'hFF) begin
            exp_fv++;
            m_seen = '0;
         end
      end
      model_q.delete();
   endfunction

   function automatic logic [63:0] model_occ();
      logic [63:0] o;
      o = '0;
      for (int r = 0; r < 8; r++)
         for (int c = 0; c < 8; c++)
            o[r*8+c] = |(((m_frame[r] >> c) | (m_frame[r] >> (c + 8)) | (m_frame[r] >> (c + 16))) & 24'd1);
      return o;
   endfunction

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #2;
   endtask

   task automatic set_katot(input logic [7:0] v);
      if (v !== katot && oe_n == 1'b0) m_oe = 1'b1;
      katot = v;
      tick(4);
   endtask

   task automatic send_bit(input bit b);
      ds = b;
      tick(3);
      sh_cp = 1'b1;
      tick(3);
      sh_cp = 1'b0;
      model_q.push_back(b);
   endtask

   task automatic send_bits(input logic [31:0] raw, input int n);
      for (int i = n - 1; i >= 0; i--) send_bit(raw[i]);
   endtask

   task automatic do_latch();
      st_cp = 1'b1;
      tick(3);
      st_cp = 1'b0;
      tick(4);
      model_latch();
   endtask

   task automatic send_word(input logic [23:0] raw, input logic [7:0] kat);
      set_katot(kat);
      send_bits({8'h00, raw}, 24);
      do_latch();
   endtask

   task automatic pulse_err_clr();
      err_clr = 1'b1;
      tick(1);
      err_clr = 1'b0;
      m_len = 1'b0;
      m_row = 1'b0;
      m_oe  = 1'b0;
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      tick(3);
      checks++;
      if (row_word !== 24'h0 || row_idx !== 3'd0) begin
         errors++;
         $display("[TB] FAIL reset_row: word=%h idx=%0d expected 0/0", row_word, row_idx);
      end
      checks++;
      if (row_valid !== 1'b0 || frame_valid !== 1'b0) begin
         errors++;
         $display("[TB] FAIL reset_pulses: rv=%b fv=%b expected 0/0", row_valid, frame_valid);
      end
      checks++;
      if (occupancy !== 64'h0) begin
         errors++;
         $display("[TB] FAIL reset_occ: got %h expected 0", occupancy);
      end
      checks++;
      if ({len_err, row_err, oe_err} !== 3'b000) begin
         errors++;
         $display("[TB] FAIL reset_flags: got %b expected 000", {len_err, row_err, oe_err});
      end
      reset_n = 1'b1;
      tick(6);
      model_reset();
      checks++;
      if ({len_err, row_err, oe_err} !== 3'b000 || rv_count !== exp_rv) begin
         errors++;
         $display("[TB] FAIL post_reset: flags=%b rv=%0d expected 000/%0d", {len_err, row_err, oe_err}, rv_count, exp_rv);
      end
   endtask

   task automatic test_frame();
      int          order [8] = '{7, 3, 0, 1, 2, 4, 5, 6};
      int          fv0;
      logic [7:0]  k;
      fv0 = exp_fv;
      for (int i = 0; i < 8; i++) begin
         k = 8'd1 << order[i];
         send_word(~24'h000001, k);
         checks++;
         if (fv_count !== fv0 + ((i == 7) ? 1 : 0) || rv_count !== exp_rv) begin
            errors++;
            $display("[TB] FAIL frame_pulse row %0d: fv=%0d rv=%0d expected %0d/%0d", order[i], fv_count, rv_count, fv0 + ((i == 7) ? 1 : 0), exp_rv);
         end
      end
      for (int r = 0; r < 8; r++) begin
         checks++;
         if (occupancy[r*8] !== 1'b1) begin
            errors++;
            $display("[TB] FAIL frame_occ row %0d: got %b expected 1", r, occupancy[r*8]);
         end
      end
      send_word(~24'h000001, 8'h10);
      checks++;
      if (fv_count !== fv0 + 1 || occupancy !== model_occ()) begin
         errors++;
         $display("[TB] FAIL frame_recommit: fv=%0d occ=%h expected %0d/%h", fv_count, occupancy, fv0 + 1, model_occ());
      end
   endtask

   task automatic test_basic();
      send_word(24'h00FF00, 8'b0000_0100);
      checks++;
      if (rv_count !== exp_rv) begin
         errors++;
         $display("[TB] FAIL basic_rv: got %0d expected %0d", rv_count, exp_rv);
      end
      checks++;
      if (row_word !== 24'hFF00FF || row_idx !== 3'd2) begin
         errors++;
         $display("[TB] FAIL basic_word: got %h/%0d expected ff00ff/2", row_word, row_idx);
      end
      checks++;
      if (occupancy[23:16] !== 8'hFF || occupancy !== model_occ()) begin
         errors++;
         $display("[TB] FAIL basic_occ: got %h expected %h", occupancy, model_occ());
      end
      checks++;
      if ({len_err, row_err, oe_err} !== 3'b000) begin
         errors++;
         $display("[TB] FAIL basic_flags: got %b expected 000", {len_err, row_err, oe_err});
      end
   endtask

   task automatic test_len_err();
      logic [23:0] raw;
      raw = 24'($urandom);
      set_katot(8'h08);
      send_bits({8'h00, raw}, 23);
      do_latch();
      checks++;
      if (len_err !== 1'b1 || rv_count !== exp_rv || occupancy !== model_occ()) begin
         errors++;
         $display("[TB] FAIL len_short: len_err=%b rv=%0d occ=%h expected 1/%0d/%h", len_err, rv_count, occupancy, exp_rv, model_occ());
      end
      raw = 24'($urandom);
      send_word(raw, 8'h08);
      checks++;
      if (row_word !== ~raw || row_idx !== 3'd3 || rv_count !== exp_rv || len_err !== 1'b1) begin
         errors++;
         $display("[TB] FAIL len_recover: word=%h idx=%0d rv=%0d len=%b expected %h/3/%0d/1", row_word, row_idx, rv_count, len_err, ~raw, exp_rv);
      end
   endtask

   task automatic test_row_err();
      send_word(24'($urandom), 8'b0001_0001);
      checks++;
      if (row_err !== 1'b1 || rv_count !== exp_rv || occupancy !== model_occ()) begin
         errors++;
         $display("[TB] FAIL row_err: row_err=%b rv=%0d expected 1/%0d", row_err, rv_count, exp_rv);
      end
      pulse_err_clr();
      checks++;
      if ({len_err, row_err, oe_err} !== 3'b000) begin
         errors++;
         $display("[TB] FAIL err_clr: got %b expected 000", {len_err, row_err, oe_err});
      end
   endtask

   task automatic test_oe();
      set_katot(8'h01);
      oe_n = 1'b0;
      tick(4);
      set_katot(8'h02);
      checks++;
      if (oe_err !== 1'b1 || m_oe !== 1'b1) begin
         errors++;
         $display("[TB] FAIL oe_lit_switch: got %b expected 1", oe_err);
      end
      oe_n = 1'b1;
      tick(4);
      pulse_err_clr();
      set_katot(8'h01);
      set_katot(8'h02);
      checks++;
      if (oe_err !== m_oe) begin
         errors++;
         $display("[TB] FAIL oe_blank_switch: got %b expected %b", oe_err, m_oe);
      end
   endtask

   task automatic test_simultaneous();
      logic [23:0] raw1, raw2;
      bit          b;
      raw1 = 24'($urandom);
      raw2 = 24'($urandom);
      b    = raw2[23];
      set_katot(8'h40);
      send_bits({8'h00, raw1}, 24);
      ds = b;
      tick(3);
      sh_cp = 1'b1;
      st_cp = 1'b1;
      tick(3);
      sh_cp = 1'b0;
      st_cp = 1'b0;
      tick(4);
      model_latch();
      model_q.push_back(b);
      checks++;
      if (row_word !== ~raw1 || rv_count !== exp_rv || len_err !== 1'b0) begin
         errors++;
         $display("[TB] FAIL simul_latch: word=%h rv=%0d len=%b expected %h/%0d/0", row_word, rv_count, len_err, ~raw1, exp_rv);
      end
      send_bits({8'h00, raw2}, 23);
      do_latch();
      checks++;
      if (row_word !== ~raw2 || row_word !== exp_word || len_err !== m_len) begin
         errors++;
         $display("[TB] FAIL simul_next: word=%h len=%b expected %h/%b", row_word, len_err, ~raw2, m_len);
      end
   endtask

   task automatic test_sr_clear();
      logic [23:0] raw;
      raw = 24'($urandom);
      set_katot(8'h20);
      send_bits($urandom, 10);
      sr_clr_n = 1'b0;
      tick(5);
      model_q.delete();
      sr_clr_n = 1'b1;
      tick(5);
      send_bits({8'h00, raw}, 24);
      do_latch();
      checks++;
      if (row_word !== ~raw || row_idx !== 3'd5 || rv_count !== exp_rv || len_err !== m_len) begin
         errors++;
         $display("[TB] FAIL sr_clear: word=%h idx=%0d len=%b expected %h/5/%b", row_word, row_idx, len_err, ~raw, m_len);
      end
   endtask

   task automatic test_reset_midframe();
      int         perm [8];
      int         j, t, fv0;
      logic [7:0] k;
      for (int r = 0; r < 3; r++) send_word(24'($urandom), 8'd1 << r);
      send_bits($urandom, 10);
      reset_n = 1'b0;
      #1;
      checks++;
      if (occupancy !== 64'h0 || row_valid !== 1'b0 || row_word !== 24'h0) begin
         errors++;
         $display("[TB] FAIL midframe_reset: occ=%h rv=%b word=%h expected 0", occupancy, row_valid, row_word);
      end
      tick(3);
      reset_n = 1'b1;
      tick(6);
      model_reset();
      fv0 = exp_fv;
      for (int i = 0; i < 8; i++) perm[i] = i;
      for (int i = 7; i > 0; i--) begin
         j = $urandom_range(0, i);
         t = perm[i];
         perm[i] = perm[j];
         perm[j] = t;
      end
      for (int i = 0; i < 8; i++) begin
         k = 8'd1 << perm[i];
         send_word(24'($urandom), k);
         checks++;
         if (fv_count !== fv0 + ((i == 7) ? 1 : 0) || occupancy !== model_occ()) begin
            errors++;
            $display("[TB] FAIL midframe_refill %0d: fv=%0d occ=%h expected %0d/%h", i, fv_count, occupancy, fv0 + ((i == 7) ? 1 : 0), model_occ());
         end
      end
   endtask

   task automatic test_random();
      logic [7:0]  k;
      logic [31:0] raw;
      int          len, sel;
      for (int it = 0; it < 30; it++) begin
         sel = $urandom_range(0, 9);
         k   = (sel < 8) ? (8'd1 << $urandom_range(0, 7)) : 8'($urandom_range(0, 255));
         sel = $urandom_range(0, 9);
         len = (sel == 0) ? 23 : (sel == 1) ? 25 : 24;
         raw = $urandom;
         set_katot(k);
         send_bits(raw, len);
         do_latch();
         checks++;
         if (rv_count !== exp_rv || fv_count !== exp_fv) begin
            errors++;
            $display("[TB] FAIL rand_pulses %0d: rv=%0d fv=%0d expected %0d/%0d", it, rv_count, fv_count, exp_rv, exp_fv);
         end
         checks++;
         if (row_word !== exp_word || row_idx !== 3'(exp_idx)) begin
            errors++;
            $display("[TB] FAIL rand_word %0d: got %h/%0d expected %h/%0d", it, row_word, row_idx, exp_word, exp_idx);
         end
         checks++;
         if (occupancy !== model_occ()) begin
            errors++;
            $display("[TB] FAIL rand_occ %0d: got %h expected %h", it, occupancy, model_occ());
         end
         checks++;
         if ({len_err, row_err, oe_err} !== {m_len, m_row, m_oe}) begin
            errors++;
            $display("[TB] FAIL rand_flags %0d: got %b expected %b", it, {len_err, row_err, oe_err}, {m_len, m_row, m_oe});
         end
         if (it % 8 == 7) pulse_err_clr();
      end
   endtask

   // Scenario sequence; the frame test must follow a reset so that the
   // seen-mask starts empty.
   initial begin
      reset_n  = 1'b0;
      sh_cp    = 1'b0;
      st_cp    = 1'b0;
      ds       = 1'b0;
      oe_n     = 1'b1;
      sr_clr_n = 1'b1;
      katot    = 8'h00;
      err_clr  = 1'b0;
      model_reset();
      $display("[TB] starting matrix_stream_capture bench");
      test_reset();
      test_frame();
      test_basic();
      test_len_err();
      test_row_err();
      test_oe();
      test_simultaneous();
      test_sr_clear();
      test_reset_midframe();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
